mem_align_unit: RTL and testbench
=================================

// Module: mem_align_unit
// PURPOSE
//  Memory-stage access unit for the pipelined MIPS core. Stores: narrows byte/half/word
//  data into an aligned word plus byte enables. Loads: extracts the addressed lane and
//  sign- or zero-extends it to 32 bits. Owns the request/response handshake to data
//  memory, detects misalignment (AdEL/AdES) and raises a bus-error timeout.
// PARAMETERS
//  TIMEOUT   255  max cycles in WAIT_R before bus error; 0 = never time out
// PORTS
//  clk          in   1   clock; all state on rising edge
//  reset        in   1   asynchronous, active-low; 0 forces reset state immediately
//  req_valid    in   1   pipeline presents access this cycle
//  req_ready    out  1   unit can accept (high only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned in   1   load: 1 = zero-extend (lbu/lhu), 0 = sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified
//  mem_valid    out  1   memory request valid
//  mem_ready    in   1   memory accepts request when mem_valid & mem_ready
//  mem_addr     out  32  {req_addr[31:2],2'b00}
//  mem_we       out  1   registered req_we
//  mem_byteen   out  4   byte enables (all 1 on loads)
//  mem_wdata    out  32  lane-replicated store data
//  mem_rvalid   in   1   read data returned
//  mem_rdata    in   32  read word
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_exc      out  2   00 ok, 01 AdEL, 10 AdES, 11 bus error; valid with rsp_valid
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_valid=0, mem_we=0, mem_addr/byteen/wdata=0;
//   rsp_valid=0, rsp_rdata=0, rsp_exc=00; timeout counter=0. Outputs all registered.
//  FSM: IDLE -> REQ -> (store) RESP | (load) WAIT_R -> RESP -> IDLE; IDLE -> RESP on error.
//  IDLE: accept on req_valid&req_ready at cycle T; compute lanes, register request.
//   Misaligned (half & addr[0]) | (word & addr[1:0]!=0) | size==11 -> no mem access;
//   RESP at T+1 with rsp_exc=AdES (store) / AdEL (load).
//  REQ: mem_valid held with stable addr/we/byteen/wdata until mem_ready; handshake at S:
//   store -> rsp_valid at S+1; load -> WAIT_R, counter cleared.
//  WAIT_R: mem_rvalid at R -> rsp_valid at R+1 with extended data. Counter increments
//   each cycle; when it reaches TIMEOUT without rvalid -> RESP with exc=11, rdata=0.
//   rvalid coincident with timeout cycle wins (normal data).
//  RESP: rsp_valid=1 exactly one cycle, then IDLE; req_ready returns at next cycle.
//  mem_rvalid outside WAIT_R ignored. No response backpressure; pipeline stalls on
//   !req_ready or until rsp_valid.
//  Lanes: a=addr[1:0]. byte: byteen=4'b0001<<a, wdata={4{wd[7:0]}};
//   half: byteen=4'b0011<<{a[1],1'b0}, wdata={2{wd[15:0]}}; word: 4'b1111, wd.
//  Load extract: byte=rdata[8a+7:8a], half=rdata[16a1+15:16a1], extended per
//   req_unsigned (registered at accept); word ignores req_unsigned.
//  Reset mid-operation: abandon transaction, return to reset state; late rvalid ignored.
// TESTING
//  sb addr=0x..03 wd=0x000000AB -> mem_byteen=1000, mem_wdata=0xABABABAB, rsp_exc=00
//  lb addr=0x..01, rdata=0x1234_80FF, unsigned=0 -> rsp_rdata=0xFFFFFF80; lbu -> 0x00000080
//  lh addr=0x..02, rdata=0x8001_0000 -> 0xFFFF8001; lw addr=0x..02 -> no mem_valid, exc=01
//  mem_ready low 3 cycles -> mem_* stable, rsp_valid exactly 1 cycle after handshake
//  TIMEOUT=4, load, no rvalid -> rsp exc=11 rdata=0; late rvalid in IDLE ignored
//  reset low during WAIT_R -> all outputs 0, req_ready=1, next load completes normally

Source files
------------

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - MIPS memory-stage access unit: store lane steering, load extraction, handshake, AdEL/AdES and bus timeout
module mem_align_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_byteen,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_exc
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REQ    = 2'd1;
   localparam logic [1:0] WAIT_R = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] EXC_OK   = 2'b00;
   localparam logic [1:0] EXC_ADEL = 2'b01;
   localparam logic [1:0] EXC_ADES = 2'b10;
   localparam logic [1:0] EXC_BUS  = 2'b11;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    lane_r;
   logic [1:0]    size_r;
   logic          unsigned_r;

   logic [1:0]    a;
   logic          misalign;
   logic [3:0]    byteen_c;
   logic [31:0]   wdata_c;
   logic [7:0]    lbyte;
   logic [15:0]   lhalf;
   logic [31:0]   ld_data;

   // Store lane steering from the live request; loads read the whole word.
   always_comb begin
      a        = req_addr[1:0];
      misalign = (req_size == 2'b11) ||
                 ((req_size == 2'b01) && a[0]) ||
                 ((req_size == 2'b10) && (a != 2'b00));
      byteen_c = 4'b1111;
      wdata_c  = req_wdata;
      case (req_size)
         2'b00: begin
            byteen_c = 4'b0001 << a;
            wdata_c  = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byteen_c = 4'b0011 << {a[1], 1'b0};
            wdata_c  = {2{req_wdata[15:0]}};
         end
         default: begin
            byteen_c = 4'b1111;
            wdata_c  = req_wdata;
         end
      endcase
      if (!req_we) begin
         byteen_c = 4'b1111;
         wdata_c  = 32'd0;
      end
   end

   // Load extraction uses the lane/size/sign captured at accept time.
   always_comb begin
      lbyte   = mem_rdata[{lane_r, 3'b000} +: 8];
      lhalf   = mem_rdata[{lane_r[1], 4'b0000} +: 16];
      ld_data = mem_rdata;
      case (size_r)
         2'b00:   ld_data = unsigned_r ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
         2'b01:   ld_data = unsigned_r ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
         default: ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lane_r     <= 2'b00;
         size_r     <= 2'b00;
         unsigned_r <= 1'b0;
         req_ready  <= 1'b1;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_byteen <= 4'd0;
         mem_wdata  <= 32'd0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'd0;
         rsp_exc    <= EXC_OK;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  lane_r     <= req_addr[1:0];
                  size_r     <= req_size;
                  unsigned_r <= req_unsigned;
                  if (misalign) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'd0;
                     rsp_exc   <= req_we ? EXC_ADES : EXC_ADEL;
                  end else begin
                     state      <= REQ;
                     mem_valid  <= 1'b1;
                     mem_we     <= req_we;
                     mem_addr   <= {req_addr[31:2], 2'b00};
                     mem_byteen <= byteen_c;
                     mem_wdata  <= wdata_c;
                  end
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (mem_we) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'd0;
                     rsp_exc   <= EXC_OK;
                  end else begin
                     state <= WAIT_R;
                     cnt   <= '0;
                  end
               end
            end
            WAIT_R: begin
               // Data arriving on the timeout cycle still completes normally.
               if (mem_rvalid) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= ld_data;
                  rsp_exc   <= EXC_OK;
               end else if ((TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1))) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= 32'd0;
                  rsp_exc   <= EXC_BUS;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - scoreboard bench for mem_align_unit with directed vectors
module tb_mem_align_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_exc;

   int checks = 0;
   int fails  = 0;
   logic [33:0] sb[$];
   logic prev_rv = 1'b0;

   always #5 clk = ~clk;

   mem_align_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Response monitor: every rsp_valid must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && rsp_valid) begin
         if (prev_rv) chk("rsp_pulse_width", 64'(prev_rv), 64'(1'b0));
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp: got rdata 0x%0h exc %0d with nothing expected", rsp_rdata, rsp_exc);
         end else begin
            chk("rsp_rdata_exc", 64'({rsp_rdata, rsp_exc}), 64'(sb.pop_front()));
         end
      end
      prev_rv = reset && rsp_valid;
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, 64'({req_ready, mem_valid, mem_we, rsp_valid, rsp_exc}), 64'(6'b100000));
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_mem_byteen_wdata"}, 64'({mem_byteen, mem_wdata}), 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
   endtask

   task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_wait, input int rv_wait,
                         input logic [3:0] eb, input logic [31:0] ew,
                         input logic [31:0] erd, input logic [1:0] eexc);
      bit mem_exp;
      mem_exp = (eexc == 2'b00) || (eexc == 2'b11);
      sb.push_back({erd, eexc});
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_exp) begin
         chk("mem_valid", 64'(mem_valid), 64'(1'b1));
         chk("mem_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
         chk("mem_we_byteen_wdata", 64'({mem_we, mem_byteen, mem_wdata}), 64'({we, eb, ew}));
         for (int i = 0; i < rdy_wait; i++) begin
            @(negedge clk);
            chk("mem_stable", 64'({mem_valid, mem_we, mem_byteen, mem_wdata}), 64'({1'b1, we, eb, ew}));
            chk("mem_addr_stable", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
         end
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         chk("mem_valid_drop", 64'(mem_valid), 64'(1'b0));
         if (we) begin
            chk("store_rsp_latency", 64'(rsp_valid), 64'(1'b1));
         end else if (rv_wait >= 0) begin
            repeat (rv_wait) @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk("load_rsp_latency", 64'(rsp_valid), 64'(1'b1));
         end
      end else begin
         chk("no_mem_access", 64'(mem_valid), 64'(1'b0));
      end
      for (int i = 0; i < 40 && !(sb.size() == 0 && req_ready); i++) @(negedge clk);
      if (!(sb.size() == 0 && req_ready)) begin
         checks++;
         fails++;
         $display("FAIL rsp_timeout: pending %0d ready %0b, required 0 pending and ready", sb.size(), req_ready);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      // we sz uns addr wd rd rdy rv byteen wdata exp_rdata exp_exc
      access(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0, 0, 4'b1000, 32'hABAB_ABAB, 32'd0, 2'b00);
      access(1, 2'b01, 0, 32'h0000_2002, 32'h1234_CAFE, 32'd0, 1, 0, 4'b1100, 32'hCAFE_CAFE, 32'd0, 2'b00);
      access(1, 2'b10, 0, 32'h0000_3000, 32'hDEAD_BEEF, 32'd0, 3, 0, 4'b1111, 32'hDEAD_BEEF, 32'd0, 2'b00);
      access(0, 2'b00, 0, 32'h0000_2001, 32'd0, 32'h1234_80FF, 0, 0, 4'b1111, 32'd0, 32'hFFFF_FF80, 2'b00);
      access(0, 2'b00, 1, 32'h0000_2001, 32'd0, 32'h1234_80FF, 0, 2, 4'b1111, 32'd0, 32'h0000_0080, 2'b00);
      access(0, 2'b01, 0, 32'h0000_2002, 32'd0, 32'h8001_0000, 2, 1, 4'b1111, 32'd0, 32'hFFFF_8001, 2'b00);
      access(0, 2'b01, 1, 32'h0000_2000, 32'd0, 32'h8001_F00D, 0, 0, 4'b1111, 32'd0, 32'h0000_F00D, 2'b00);
      access(0, 2'b10, 0, 32'h0000_2004, 32'd0, 32'h89AB_CDEF, 0, 1, 4'b1111, 32'd0, 32'h89AB_CDEF, 2'b00);
      access(0, 2'b10, 0, 32'h0000_2002, 32'd0, 32'd0, 0, 0, 4'b1111, 32'd0, 32'd0, 2'b01);
      access(1, 2'b01, 0, 32'h0000_3001, 32'h0000_5555, 32'd0, 0, 0, 4'b0000, 32'd0, 32'd0, 2'b10);
      access(0, 2'b11, 0, 32'h0000_3000, 32'd0, 32'd0, 0, 0, 4'b1111, 32'd0, 32'd0, 2'b01);
      access(0, 2'b10, 1, 32'h0000_4000, 32'd0, 32'hA5A5_0F0F, 0, 3, 4'b1111, 32'd0, 32'hA5A5_0F0F, 2'b00);
      access(0, 2'b10, 0, 32'h0000_5000, 32'd0, 32'd0, 0, -1, 4'b1111, 32'd0, 32'd0, 2'b11);

      // Late read data while idle must not produce a response.
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_rvalid_idle", 64'({rsp_valid, req_ready}), 64'(2'b01));
      end

      // Reset asserted while waiting for read data abandons the load.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_6004;
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      reset = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("post_reset_no_rsp", 64'({rsp_valid, req_ready}), 64'(2'b01));
      @(negedge clk);
      access(0, 2'b00, 0, 32'h0000_6003, 32'd0, 32'h7F00_0000, 0, 1, 4'b1111, 32'd0, 32'h0000_007F, 2'b00);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
